// File: rtl/fir_pkg.sv
// Shared defaults, FSM state type and reset-time coefficient set for the
// sequential FIR multiply-accumulate filter.
package fir_pkg;

  localparam int NTAPS_D  = 4;
  localparam int DATA_W_D = 8;
  localparam int ACC_W_D  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [DATA_W_D-1:0] COEF_DEFAULT [NTAPS_D] = '{
    8'sd1, 8'sd2, 8'sd3, 8'sd4
  };

  // Taps beyond the default table (larger NTAPS builds) come up as zero.
  function automatic logic signed [DATA_W_D-1:0] default_coef(input int idx);
    logic signed [DATA_W_D-1:0] c;
    c = '0;
    for (int i = 0; i < NTAPS_D; i++) begin
      if (i == idx) c = COEF_DEFAULT[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed multiplier feeding a wrapping accumulator; one product per
// enabled cycle, cleared at the start of every output sample.
module fir_mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [DATA_W-1:0] coef,
  output logic signed [ACC_W-1:0]  sum_next
);

  localparam int WW = ((ACC_W > 2*DATA_W) ? ACC_W : 2*DATA_W) + 1;

  logic signed [2*DATA_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]    acc_p1;

  // Two's-complement wrap: extend both operands, add, keep the low ACC_W bits.
  function automatic logic signed [ACC_W-1:0] wrap_add(
    input logic signed [ACC_W-1:0]    a,
    input logic signed [2*DATA_W-1:0] p
  );
    logic signed [WW-1:0] wide;
    wide = WW'(a) + WW'(p);
    return wide[ACC_W-1:0];
  endfunction

  // p0: full-precision product of the current tap
  assign prod_p0  = sample * coef;
  assign sum_next = wrap_add(acc_p1, prod_p0);

  // p1: running sum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   acc_p1 <= '0;
    else if (clr) acc_p1 <= '0;
    else if (en)  acc_p1 <= sum_next;
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// NTAPS-tap FIR filter that time-shares one multiplier: accept a sample,
// walk the taps one per cycle, then publish the result for one cycle.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS  = NTAPS_D,
  parameter int DATA_W = DATA_W_D,
  parameter int ACC_W  = ACC_W_D,
  localparam int PW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  output logic signed [ACC_W-1:0]  y_out,
  output logic                     out_valid,
  input  logic                     clear,
  input  logic                     coef_we,
  input  logic [PW-1:0]            coef_addr,
  input  logic signed [DATA_W-1:0] coef_wdata,
  output logic                     coef_err,
  output logic                     busy
);

  localparam logic [PW:0]   NTAPS_V  = (PW+1)'(NTAPS);
  localparam logic [PW-1:0] LAST_TAP = PW'(NTAPS - 1);

  state_t state, state_next;
  logic   armed;

  logic [PW-1:0] wptr, head, tap, rd_idx;
  logic [PW:0]   rd_sum;

  logic signed [DATA_W-1:0] dline [NTAPS];
  logic signed [DATA_W-1:0] coef  [NTAPS];

  logic accept, last_tap, mac_en, acc_clr;
  logic signed [ACC_W-1:0] sum_next;

  // armed keeps in_ready low until the first edge after reset release
  assign in_ready = armed && (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready && !clear;
  assign last_tap = (state == MAC) && (tap == LAST_TAP);
  assign mac_en   = (state == MAC) && !clear;
  assign acc_clr  = accept || clear;

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = MAC;
        MAC:     if (tap == LAST_TAP) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
    end
  end

  // Tap k reads x[n-k], i.e. k slots behind the newest entry, modulo NTAPS.
  always_comb begin
    rd_sum = {1'b0, head} - {1'b0, tap};
    if (tap > head) rd_sum = rd_sum + NTAPS_V;
    rd_idx = rd_sum[PW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      head <= '0;
      tap  <= '0;
      for (int i = 0; i < NTAPS; i++) dline[i] <= '0;
    end else if (clear) begin
      wptr <= '0;
      head <= '0;
      tap  <= '0;
      for (int i = 0; i < NTAPS; i++) dline[i] <= '0;
    end else if (accept) begin
      dline[wptr] <= x_in;
      head        <= wptr;
      wptr        <= (wptr == LAST_TAP) ? '0 : wptr + 1'b1;
      tap         <= '0;
    end else if (state == MAC) begin
      tap <= tap + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) coef[i] <= DATA_W'(default_coef(i));
    end else if (coef_we && (state == IDLE) && (int'(coef_addr) < NTAPS)) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clr      (acc_clr),
    .en       (mac_en),
    .sample   (dline[rd_idx]),
    .coef     (coef[tap]),
    .sum_next (sum_next)
  );

  // Result is captured together with the last product so it is valid during DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_out     <= '0;
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
    end else begin
      out_valid <= last_tap && !clear;
      coef_err  <= coef_we && busy;
      if (last_tap && !clear) y_out <= sum_next;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed scoreboard bench for fir_mac_sequencer: the driver queues expected
// results at each accept, a negedge monitor pops them as out_valid appears.
module tb_fir_mac_sequencer;

  localparam int NTAPS  = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int PW     = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [DATA_W-1:0] x_in = '0;
  logic signed [ACC_W-1:0]  y_out;
  logic out_valid;
  logic clear = 1'b0;
  logic coef_we = 1'b0;
  logic [PW-1:0] coef_addr = '0;
  logic signed [DATA_W-1:0] coef_wdata = '0;
  logic coef_err;
  logic busy;

  fir_mac_sequencer #(
    .NTAPS  (NTAPS),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_in       (x_in),
    .y_out      (y_out),
    .out_valid  (out_valid),
    .clear      (clear),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_err   (coef_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [ACC_W-1:0] y;
    int                      acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int passes   = 0;
  int ov_count = 0;
  int ov_before;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      ov_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("y_out", y_out, e.y);
        chk("out_valid_latency", cyc - e.acc_cyc, NTAPS);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Called on a negedge; returns on the negedge right after the accept edge.
  task automatic send(input int x, input int y, input bit push, input bit check_gap);
    exp_t e;
    int   low;
    wait_ready();
    in_valid = 1'b1;
    x_in     = x[DATA_W-1:0];
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (push) begin
      e.y       = y[ACC_W-1:0];
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
    if (check_gap) begin
      low = 0;
      while (!in_ready && low < 50) begin
        low++;
        @(negedge clk);
      end
      chk("in_ready_low_cycles", low, NTAPS + 1);
    end
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we    = 1'b1;
    coef_addr  = addr[PW-1:0];
    coef_wdata = val[DATA_W-1:0];
    @(posedge clk);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_coef_err", coef_err, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_after_release", in_ready, 1);

    // impulse through default coefficients
    send(1, 1, 1, 0);
    send(0, 2, 1, 0);
    send(0, 3, 1, 0);
    send(0, 4, 1, 0);
    send(0, 0, 1, 0);
    wait_drain();

    // ramp, also checking the in_ready gap after each accept
    send(1, 1, 1, 1);
    send(2, 4, 1, 1);
    send(3, 10, 1, 1);
    send(4, 20, 1, 1);
    send(5, 30, 1, 1);
    wait_drain();

    // clear during the second MAC cycle discards the sample and history
    ov_before = ov_count;
    send(9, 0, 0, 0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_busy", busy, 0);
    chk("clear_in_ready", in_ready, 1);
    repeat (NTAPS + 3) @(negedge clk);
    chk("clear_no_out_valid", ov_count, ov_before);

    // clear beats a simultaneous handshake
    in_valid = 1'b1;
    x_in     = 8'sd7;
    clear    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    chk("clear_priority_busy", busy, 0);

    send(1, 1, 1, 0);
    send(0, 2, 1, 0);
    send(0, 3, 1, 0);
    send(0, 4, 1, 0);
    wait_drain();

    // coefficient write while busy is dropped, then applied from IDLE
    send(2, 2, 1, 0);
    coef_we    = 1'b1;
    coef_addr  = 2'd0;
    coef_wdata = 8'sd10;
    @(negedge clk);
    coef_we = 1'b0;
    chk("coef_err_pulse", coef_err, 1);
    @(negedge clk);
    chk("coef_err_one_cycle", coef_err, 0);
    wait_ready();
    write_coef(0, 10);
    chk("coef_err_idle_write", coef_err, 0);
    send(3, 34, 1, 0);
    wait_drain();

    // accumulator wrap with all coefficients at 127
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < NTAPS; i++) write_coef(i, 127);
    send(127, 16129, 1, 0);
    send(127, 32258, 1, 0);
    send(127, -17149, 1, 0);
    send(127, -1020, 1, 0);
    wait_drain();

    // reset in the middle of a MAC sequence
    ov_before = ov_count;
    send(5, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midmac_rst_y_out", y_out, 0);
    chk("midmac_rst_in_ready", in_ready, 0);
    chk("midmac_rst_busy", busy, 0);
    chk("midmac_rst_out_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    chk("midmac_rst_held_in_ready", in_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midmac_release_in_ready", in_ready, 1);
    repeat (NTAPS + 2) @(negedge clk);
    chk("midmac_no_out_valid", ov_count, ov_before);

    // reset restored the default coefficients and an empty delay line
    send(1, 1, 1, 0);
    send(0, 2, 1, 0);
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
